// File: rtl/rs232_pkg.sv
// -----------------------------------------------------------------------------
// rs232_pkg
//    Shared definitions for the RS-232 transmitter slice.
//    - state_t       : transmitter FSM states (PARITY only reachable when the
//                      RS232_TX_PARITY_EN macro is defined)
//    - DATA_BITS     : payload width of one frame
//    - IDLE_LEVEL    : logic level of the idle (marking) serial line
//    - even_parity() : parity bit that makes the count of ones even
//    - cnt_width()   : register width able to hold 0..n-1 (at least 1 bit)
// -----------------------------------------------------------------------------
package rs232_pkg;

   localparam int unsigned DATA_BITS  = 8;
   localparam logic        IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rs232_baud_gen.sv
// -----------------------------------------------------------------------------
// rs232_baud_gen
//    Bit-period timer for the transmitter. Counts clock cycles 0..BIT_CYCLES-1
//    and wraps at the bit boundary; bit_done is high during the last cycle of
//    each bit period.
//
//    Parameters:
//       CLK_FREQ  system clock frequency in Hz
//       BAUD      line bit rate in bit/s
//    Ports:
//       clk       system clock, rising edge
//       rst_n     asynchronous active-low reset
//       clear     holds the counter at zero (asserted while the line is idle,
//                 so every frame starts with a fresh bit period)
//       bit_done  one-cycle tick every BIT_CYCLES clocks
// -----------------------------------------------------------------------------
module rs232_baud_gen #(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 19200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic bit_done
);
   import rs232_pkg::*;

   localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD;
   localparam int unsigned CNT_W      = cnt_width(BIT_CYCLES);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);

   logic [CNT_W-1:0] cycle_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
      end else if (clear) begin
         cycle_cnt <= '0;
      end else if (cycle_cnt == LAST_CNT) begin
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 1'b1;
      end
   end

   assign bit_done = !clear && (cycle_cnt == LAST_CNT);

endmodule

// File: rtl/rs232_transmitter.sv
// -----------------------------------------------------------------------------
// rs232_transmitter
//    UART/RS-232 serial transmitter. Accepts one byte per single-cycle
//    data_ready strobe while idle and sends it as an 8N1 frame (start bit,
//    8 data bits LSB first, stop bit). Strobes during a frame are ignored.
//
//    Optional feature (macro RS232_TX_PARITY_EN): inserts an even-parity bit
//    between data bit 7 and the stop bit (8E1 frame, 11 bit periods).
//
//    Parameters:
//       CLK_FREQ    system clock frequency in Hz
//       BAUD        line bit rate in bit/s
//    Ports:
//       clk         system clock, rising edge
//       rst_n       asynchronous active-low reset (aborts any frame)
//       data_ready  one-cycle strobe, data valid / start a frame
//       data        byte to transmit, sampled only when the strobe is accepted
//       tx          registered serial line output, idle level 1
//       rts         registered: 1 = idle and ready, 0 = frame in progress
// -----------------------------------------------------------------------------
module rs232_transmitter #(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 19200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       data_ready,
   input  logic [7:0] data,
   output logic       tx,
   output logic       rts
);
   import rs232_pkg::*;

   localparam int unsigned IDX_W = cnt_width(DATA_BITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   state_t                 state;
   logic [DATA_BITS-1:0]   shift_reg;
   logic [IDX_W-1:0]       bit_idx;
   logic                   bit_done;

   // The bit timer runs only while a frame is in flight; holding it clear in
   // IDLE means the accept edge starts a full-length start bit.
   rs232_baud_gen #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) u_baud_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (state == IDLE),
      .bit_done (bit_done)
   );

   // tx/rts are assigned the level of the state being entered, so both are
   // registered and change on the same edge as the state transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tx        <= IDLE_LEVEL;
         rts       <= 1'b1;
         bit_idx   <= '0;
         shift_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx  <= IDLE_LEVEL;
               rts <= 1'b1;
               if (data_ready) begin
                  shift_reg <= data;
                  bit_idx   <= '0;
                  state     <= START;
                  tx        <= ~IDLE_LEVEL;
                  rts       <= 1'b0;
               end
            end

            START: begin
               if (bit_done) begin
                  state   <= DATA;
                  bit_idx <= '0;
                  tx      <= shift_reg[0];
               end
            end

            DATA: begin
               if (bit_done) begin
                  if (bit_idx == LAST_IDX) begin
`ifdef RS232_TX_PARITY_EN
                     state <= PARITY;
                     tx    <= even_parity(shift_reg);
`else
                     state <= STOP;
                     tx    <= IDLE_LEVEL;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     tx      <= shift_reg[bit_idx + 1'b1];
                  end
               end
            end

            PARITY: begin
`ifdef RS232_TX_PARITY_EN
               if (bit_done) begin
                  state <= STOP;
                  tx    <= IDLE_LEVEL;
               end
`else
               state <= IDLE;
               tx    <= IDLE_LEVEL;
               rts   <= 1'b1;
`endif
            end

            STOP: begin
               if (bit_done) begin
                  state <= IDLE;
                  tx    <= IDLE_LEVEL;
                  rts   <= 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               tx    <= IDLE_LEVEL;
               rts   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rs232_transmitter.sv
// -----------------------------------------------------------------------------
// tb_rs232_transmitter
//    Self-checking bench for rs232_transmitter, run with a short bit period
//    (CLK_FREQ/BAUD = 16) so complete frames stay cheap to simulate.
//    The expected line waveform of each frame is derived from the byte:
//    start 0, data LSB first, optional even parity, stop 1, each for
//    BIT_CYCLES clocks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rs232_transmitter;

   localparam int unsigned CLK_FREQ   = 1600;
   localparam int unsigned BAUD       = 100;
   localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD;
`ifdef RS232_TX_PARITY_EN
   localparam int unsigned NSLOTS = 11;
`else
   localparam int unsigned NSLOTS = 10;
`endif

   logic       clk;
   logic       rst_n;
   logic       data_ready;
   logic [7:0] data;
   logic       tx;
   logic       rts;

   int n_cmp;
   int n_err;

   rs232_transmitter #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_ready (data_ready),
      .data       (data),
      .tx         (tx),
      .rts        (rts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Line levels of one frame in transmit order (index = bit slot).
   function automatic logic [10:0] frame_bits(input logic [7:0] b);
      logic [10:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef RS232_TX_PARITY_EN
      f[9] = ^b;
`endif
      return f;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called right after the accepting clock edge. Optionally drives a
   // one-cycle strobe with another byte at frame cycle inject_at.
   task automatic check_frame(input logic [7:0] b, input int inject_at, input logic [7:0] inj);
      logic [10:0]           f;
      logic [BIT_CYCLES-1:0] obs;
      int                    low;
      int                    k;
      f   = frame_bits(b);
      low = 0;
      k   = 0;
      for (int s = 0; s < int'(NSLOTS); s++) begin
         for (int c = 0; c < int'(BIT_CYCLES); c++) begin
            @(negedge clk);
            obs[c] = tx;
            if (rts === 1'b0) low++;
            if (inject_at >= 0 && k == inject_at) begin
               data_ready = 1'b1;
               data       = inj;
            end else if (inject_at >= 0 && k == inject_at + 1) begin
               data_ready = 1'b0;
            end
            k++;
         end
         check($sformatf("slot%0d_byte%02h", s, b), 32'(obs),
               f[s] ? 32'(2**BIT_CYCLES - 1) : 32'd0);
      end
      check($sformatf("rts_low_cycles_%02h", b), 32'(low), 32'(NSLOTS * BIT_CYCLES));
      @(negedge clk);
      check("rts_back_high", 32'(rts), 32'd1);
      check("tx_idle_after", 32'(tx), 32'd1);
   endtask

   task automatic strobe(input logic [7:0] b);
      @(negedge clk);
      data_ready = 1'b1;
      data       = b;
      @(posedge clk);
      #1;
      data_ready = 1'b0;
      data       = ~b;
   endtask

   task automatic check_quiet(input string tag, input int cycles);
      int bad;
      bad = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || rts !== 1'b1) bad++;
      end
      check(tag, 32'(bad), 32'd0);
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] b2;
      n_cmp      = 0;
      n_err      = 0;
      rst_n      = 1'b0;
      data_ready = 1'b0;
      data       = 8'h00;

      // Reset state
      repeat (5) @(negedge clk);
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_rts", 32'(rts), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      check_quiet("idle_no_transitions", 20);

      // Directed bytes
      strobe(8'h6A);
      check_frame(8'h6A, -1, 8'h00);
      check_quiet("gap_after_6A", 30);
      strobe(8'hCC);
      check_frame(8'hCC, -1, 8'h00);
      strobe(8'h07);
      check_frame(8'h07, -1, 8'h00);

      // Busy rejection: second strobe mid-frame must not start a frame
      strobe(8'h6A);
      check_frame(8'h6A, 2 * BIT_CYCLES + 3, 8'hFF);
      check_quiet("no_second_frame", 3 * BIT_CYCLES);

      // data_ready held high: data changes mid-frame are not sampled, and the
      // next frame starts on the first idle cycle
      b  = 8'(($urandom % 256));
      b2 = ~b;
      @(negedge clk);
      data_ready = 1'b1;
      data       = b;
      @(posedge clk);
      #1 data = b2;
      check_frame(b, -1, 8'h00);
      @(posedge clk);
      #1 data_ready = 1'b0;
      check_frame(b2, -1, 8'h00);

      // Reset during data bit 3
      b = 8'(($urandom % 256));
      strobe(b);
      repeat (4 * BIT_CYCLES + BIT_CYCLES / 2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_tx", 32'(tx), 32'd1);
      check("midreset_rts", 32'(rts), 32'd1);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      check_quiet("after_midreset", 5);
      strobe(8'h55);
      check_frame(8'h55, -1, 8'h00);

      // Random bytes with random idle gaps
      for (int n = 0; n < 6; n++) begin
         b = 8'(($urandom % 256));
         repeat ($urandom_range(0, 7)) @(negedge clk);
         strobe(b);
         check_frame(b, -1, 8'h00);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
